// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron layer controller.
// Holds geometry, accumulator width and the sequencing states.
package nn_pkg;

  localparam int N_UNITS = 4;
  localparam int N_TAPS  = 4;
  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int ACC_W   = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_ACT,
    S_DONE
  } state_t;

  // Byte k of a packed word, byte 0 in the top lane.
  function automatic logic [BYTE_W-1:0] lane(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        k
  );
    logic [BYTE_W-1:0] b;
    unique case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Signed 8x8 multiply-accumulate, shared by all units.
// Also produces the ReLU / shift / clamp activation of the sum.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int ACC_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [BYTE_W-1:0] a,
  input  logic signed [BYTE_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic [BYTE_W-1:0]        act
);

  logic signed [2*BYTE_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-2*BYTE_W){prod[2*BYTE_W-1]}}, prod};
  assign shifted  = acc >>> ACC_SHIFT;

  // Accumulator: clear at unit start, add one product per tap.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

  // Negative sums go to zero; large sums saturate at 127.
  always_comb begin
    act = '0;
    if (acc[ACC_W-1]) begin
      act = '0;
    end else if (|shifted[ACC_W-1:BYTE_W-1]) begin
      act = 8'h7f;
    end else begin
      act = shifted[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_layer_controller.sv
// Four-unit, four-tap neuron layer sequencer.
// One MAC is time-shared: LOAD, 4x MAC, ACT per unit, then DONE.
module neuron_layer_controller
  import nn_pkg::*;
#(
  parameter int ACC_SHIFT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic [WORD_W-1:0] in_vec,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] neuron_out,
  output logic              wr_err
);

  state_t state;
  state_t state_n;

  logic [N_UNITS-1:0][WORD_W-1:0] wmem;
  logic [N_UNITS-1:0][BYTE_W-1:0] res;
  logic [WORD_W-1:0]              in_q;
  logic [WORD_W-1:0]              w_cur;
  logic [1:0]                     unit;
  logic [1:0]                     tap;

  logic                    mac_clr;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc;
  logic [BYTE_W-1:0]       act;
  logic                    idle;
  logic                    last_tap;
  logic                    last_unit;

  assign idle      = (state == S_IDLE);
  assign last_tap  = (tap == 2'(N_TAPS - 1));
  assign last_unit = (unit == 2'(N_UNITS - 1));
  assign mac_clr   = (state == S_LOAD);
  assign mac_en    = (state == S_MAC);

  neuron_mac #(
    .ACC_SHIFT (ACC_SHIFT)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (lane(w_cur, tap)),
    .b     (lane(in_q, tap)),
    .acc   (acc),
    .act   (act)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state sequencing through units and taps.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = S_MAC;
      S_MAC:  if (last_tap) state_n = S_ACT;
      S_ACT:  state_n = last_unit ? S_DONE : S_LOAD;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Weight store; writes only land while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wmem   <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !idle;
      if (wr_en && idle) begin
        wmem[wr_addr] <= wr_data;
      end
    end
  end

  // Run datapath: capture inputs, step indices, collect results.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q  <= '0;
      w_cur <= '0;
      unit  <= '0;
      tap   <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            in_q <= in_vec;
            unit <= '0;
          end
        end
        S_LOAD: begin
          w_cur <= wmem[unit];
          tap   <= '0;
        end
        S_MAC: begin
          tap <= tap + 2'd1;
        end
        S_ACT: begin
          res[2'd3 - unit] <= act;
          unit             <= unit + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Status and published result; busy covers the 24 work cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      neuron_out <= '0;
    end else begin
      busy <= !idle && (state != S_DONE);
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        neuron_out <= res;
      end
    end
  end

endmodule
